// File: rtl/port_request_collector_pkg.sv
// Shared sizing and payload/port-index types for the port request collector.
package port_request_collector_pkg;
  localparam int PORTCOUNT     = 4;
  localparam int PORTADDRWIDTH = 2;
  localparam int DATAWIDTH     = 32;

  typedef logic [PORTADDRWIDTH-1:0] portIdx_t;
  typedef logic [DATAWIDTH-1:0]     payload_t;
endpackage

// File: rtl/port_request_collector_if.sv
// Request, priority-handshake and output-stage bundle of the port request collector.
// master: clients, priority block and downstream; slave: the collector itself.
interface port_request_collector_if #(
  parameter int PORTCOUNT     = port_request_collector_pkg::PORTCOUNT,
  parameter int PORTADDRWIDTH = port_request_collector_pkg::PORTADDRWIDTH,
  parameter int DATAWIDTH     = port_request_collector_pkg::DATAWIDTH
);
  logic [PORTCOUNT-1:0]           PortReqValid;
  logic [PORTCOUNT*DATAWIDTH-1:0] PortReqData;
  logic [PORTCOUNT-1:0]           PortReqReady;
  logic [PORTCOUNT-1:0]           PortACKVector;
  logic [PORTADDRWIDTH-1:0]       PortSelection;
  logic                           OutValid;
  logic [DATAWIDTH-1:0]           OutData;
  logic [PORTADDRWIDTH-1:0]       OutPort;
  logic                           OutReady;

  modport master (
    output PortReqValid, PortReqData, PortSelection, OutReady,
    input  PortReqReady, PortACKVector, OutValid, OutData, OutPort
  );

  modport slave (
    input  PortReqValid, PortReqData, PortSelection, OutReady,
    output PortReqReady, PortACKVector, OutValid, OutData, OutPort
  );
endinterface

// File: rtl/port_request_collector_slot.sv
// One-entry holding slot: captures a payload when empty, drops it on clear.
// Capture and clear are mutually exclusive by construction (capture needs empty, clear needs full).
module port_holding_slot
  import port_request_collector_pkg::*;
#(
  parameter int WIDTH = $bits(payload_t)
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             capture,
  input  logic             clear,
  input  logic [WIDTH-1:0] dataIn,
  output logic             full,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (capture) begin
      full <= 1'b1;
      data <= dataIn;
    end
  end
endmodule

// File: rtl/port_request_collector.sv
// Collects one pending request per port, offers the pending set to the priority block and
// forwards its selection through a registered valid/ready stage (1 cycle capture-to-output).
module port_request_collector #(
  parameter int PORTCOUNT     = port_request_collector_pkg::PORTCOUNT,
  parameter int PORTADDRWIDTH = port_request_collector_pkg::PORTADDRWIDTH,
  parameter int DATAWIDTH     = port_request_collector_pkg::DATAWIDTH
) (
  input logic clk,
  input logic sync_rst,
  input logic clk_en,
  port_request_collector_if.slave bus
);
  logic [PORTCOUNT-1:0]     slotFull;
  logic [DATAWIDTH-1:0]     slotData [PORTCOUNT];
  logic [PORTCOUNT-1:0]     reqReady;
  logic [PORTCOUNT-1:0]     capture;
  logic [PORTCOUNT-1:0]     clear;
  logic                     accept;
  logic                     selFull;
  logic [DATAWIDTH-1:0]     selData;
  logic                     transfer;
  logic                     outValid;
  logic [DATAWIDTH-1:0]     outData;
  logic [PORTADDRWIDTH-1:0] outPort;

  // Ready comes from slot state only, so a draining slot cannot refill in the same cycle.
  assign reqReady = {PORTCOUNT{clk_en}} & ~slotFull;
  assign capture  = bus.PortReqValid & reqReady;
  assign accept   = clk_en && (!outValid || bus.OutReady);

  // Gating with accept keeps the priority block from rotating when no grant can be taken.
  assign bus.PortACKVector = slotFull & {PORTCOUNT{accept}};
  assign bus.PortReqReady  = reqReady;

  // Out-of-range or empty selections simply leave selFull low.
  always_comb begin
    selFull = 1'b0;
    selData = '0;
    for (int p = 0; p < PORTCOUNT; p++) begin
      if (bus.PortSelection == PORTADDRWIDTH'(p)) begin
        selFull = slotFull[p];
        selData = slotData[p];
      end
    end
  end

  assign transfer = accept && selFull;

  always_comb begin
    clear = '0;
    for (int p = 0; p < PORTCOUNT; p++) begin
      clear[p] = transfer && (bus.PortSelection == PORTADDRWIDTH'(p));
    end
  end

  for (genvar p = 0; p < PORTCOUNT; p++) begin : gSlot
    port_holding_slot #(
      .WIDTH(DATAWIDTH)
    ) uSlot (
      .clk     (clk),
      .sync_rst(sync_rst),
      .capture (capture[p]),
      .clear   (clear[p]),
      .dataIn  (bus.PortReqData[p*DATAWIDTH +: DATAWIDTH]),
      .full    (slotFull[p]),
      .data    (slotData[p])
    );
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      outValid <= 1'b0;
      outData  <= '0;
      outPort  <= '0;
    end else if (accept) begin
      outValid <= transfer;
      if (transfer) begin
        outData <= selData;
        outPort <= bus.PortSelection;
      end
    end
  end

  assign bus.OutValid = outValid;
  assign bus.OutData  = outData;
  assign bus.OutPort  = outPort;
endmodule

// File: tb/tb_port_request_collector.sv
// Directed and random stimulus against a request-level model with a round-robin priority block.
module tb_port_request_collector;
  import port_request_collector_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clkEn;
  always #5 clk = ~clk;

  port_request_collector_if bus ();

  port_request_collector dut (
    .clk     (clk),
    .sync_rst(rst),
    .clk_en  (clkEn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // stimulus
  logic [3:0]  vld;
  payload_t    dat [4];
  logic        oready;
  bit          forceSel;
  portIdx_t    forcedSel;

  // request-level model: which ports hold a request, what it carries, what sits at the output
  bit          mPend [4];
  payload_t    mData [4];
  bit          mOutV;
  payload_t    mOutD;
  int          mOutP;
  int          rrIdx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < 4; p++) begin
      mPend[p] = 0;
      mData[p] = '0;
    end
    mOutV = 0;
    mOutD = '0;
    mOutP = 0;
    rrIdx = 0;
  endtask

  task automatic cycle();
    int sel;
    bit found;
    bit acc;
    bit xfer;
    logic [3:0] pendMask;
    logic [3:0] ackExp;
    logic [3:0] readyExp;
    for (int p = 0; p < 4; p++) pendMask[p] = mPend[p];
    acc = clkEn && (!mOutV || oready);
    // priority block: first pending port at or after the rotating index
    sel = rrIdx;
    found = 0;
    for (int k = 0; k < 4; k++) begin
      if (!found && pendMask[(rrIdx + k) % 4]) begin
        sel = (rrIdx + k) % 4;
        found = 1;
      end
    end
    if (forceSel) sel = int'(forcedSel);

    bus.PortReqValid  = vld;
    for (int p = 0; p < 4; p++) bus.PortReqData[p*32 +: 32] = dat[p];
    bus.PortSelection = portIdx_t'(sel);
    bus.OutReady      = oready;
    #1;
    readyExp = clkEn ? ~pendMask : 4'b0000;
    ackExp   = acc ? pendMask : 4'b0000;
    check("PortReqReady", 32'(bus.PortReqReady), 32'(readyExp));
    check("PortACKVector", 32'(bus.PortACKVector), 32'(ackExp));

    @(posedge clk);
    #1;
    if (rst) begin
      modelReset();
    end else if (clkEn) begin
      xfer = acc && pendMask[sel];
      if (acc) begin
        mOutV = xfer;
        if (xfer) begin
          mOutD = mData[sel];
          mOutP = sel;
          mPend[sel] = 0;
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (vld[p] && !pendMask[p]) begin
          mPend[p] = 1;
          mData[p] = dat[p];
        end
      end
      if (ackExp != 4'b0000) rrIdx = (sel + 1) % 4;
    end
    check("OutValid", 32'(bus.OutValid), 32'(mOutV));
    check("OutPort", 32'(bus.OutPort), 32'(mOutP));
    check("OutData", bus.OutData, mOutD);
  endtask

  task automatic idle(input int n);
    vld = 4'b0000;
    repeat (n) cycle();
  endtask

  initial begin
    logic [3:0] seen;
    rst = 1'b1;
    clkEn = 1'b1;
    vld = 4'b0000;
    oready = 1'b1;
    forceSel = 0;
    forcedSel = '0;
    for (int p = 0; p < 4; p++) dat[p] = '0;
    bus.PortReqValid = '0;
    bus.PortReqData = '0;
    bus.PortSelection = '0;
    bus.OutReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    rst = 1'b0;
    check("reset_OutValid", 32'(bus.OutValid), 32'd0);
    check("reset_OutData", bus.OutData, 32'd0);

    // single request on port 2
    idle(1);
    vld = 4'b0100;
    dat[2] = 32'hA5;
    cycle();
    check("p2_ready_low", 32'(bus.PortReqReady[2]), 32'd0);
    vld = 4'b0000;
    cycle();
    check("p2_out_valid", 32'(bus.OutValid), 32'd1);
    check("p2_out_port", 32'(bus.OutPort), 32'd2);
    check("p2_out_data", bus.OutData, 32'hA5);
    check("p2_ready_back", 32'(bus.PortReqReady[2]), 32'd1);
    idle(2);

    // all four ports at once drain on consecutive cycles, each exactly once
    for (int p = 0; p < 4; p++) dat[p] = 32'h10 + 32'(p);
    vld = 4'b1111;
    cycle();
    vld = 4'b0000;
    seen = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("burst_valid", 32'(bus.OutValid), 32'd1);
      check("burst_nodup", 32'(seen[bus.OutPort]), 32'd0);
      seen[bus.OutPort] = 1'b1;
      check("burst_data", bus.OutData, 32'h10 + 32'(bus.OutPort));
    end
    check("burst_all_ports", 32'(seen), 32'hF);
    idle(2);

    // downstream stall with output held and three slots full
    for (int p = 0; p < 4; p++) dat[p] = 32'h20 + 32'(p);
    oready = 1'b0;
    vld = 4'b1111;
    cycle();
    vld = 4'b0000;
    cycle();
    repeat (3) begin
      cycle();
      check("stall_ack_zero", 32'(bus.PortACKVector), 32'd0);
    end
    oready = 1'b1;
    idle(5);

    // selection pointing at an empty slot while slot 3 waits
    vld = 4'b1000;
    dat[3] = 32'hC3;
    cycle();
    vld = 4'b0000;
    forceSel = 1;
    forcedSel = 2'd1;
    cycle();
    check("empty_sel_no_valid", 32'(bus.OutValid), 32'd0);
    check("empty_sel_slot3_kept", 32'(bus.PortReqReady[3]), 32'd0);
    forceSel = 0;
    cycle();
    check("slot3_forwarded", bus.OutData, 32'hC3);
    idle(2);

    // global stall with requests pending
    oready = 1'b0;
    dat[0] = 32'h30;
    dat[1] = 32'h31;
    vld = 4'b0011;
    cycle();
    vld = 4'b0000;
    cycle();
    clkEn = 1'b0;
    vld = 4'b1111;
    repeat (3) begin
      cycle();
      check("stall_ready_zero", 32'(bus.PortReqReady), 32'd0);
    end
    clkEn = 1'b1;
    oready = 1'b1;
    idle(4);

    // reset while the output is valid and two slots are full
    oready = 1'b0;
    for (int p = 0; p < 4; p++) dat[p] = 32'h40 + 32'(p);
    vld = 4'b0111;
    cycle();
    vld = 4'b0000;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    oready = 1'b1;
    check("rst_ready_all", 32'(bus.PortReqReady), 32'hF);
    repeat (4) begin
      cycle();
      check("rst_no_output", 32'(bus.OutValid), 32'd0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      vld = 4'($urandom);
      for (int p = 0; p < 4; p++) dat[p] = $urandom;
      oready = ($urandom_range(0, 3) != 0);
      clkEn = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    clkEn = 1'b1;
    oready = 1'b1;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
